// File: rtl/alu_pipe.sv
// Two-stage pipelined W-bit ALU with valid/ready on both sides; opcode in instr[7:5].
// Define ALU_FLAGS_EN to add a registered {C,Z,N,V} flags output.
module alu_pipe #(
  parameter int W   = 4,
  parameter int SHW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   instr,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dato_out,
  output logic [2:0]   op_out
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]   flags
`endif
);

  logic           s1_valid_q, s1_valid_d;
  logic [2:0]     s1_op_q;
  logic [SHW-1:0] s1_sh_q;
  logic [W-1:0]   s1_a_q, s1_b_q;
  logic           out_valid_q;
  logic [W-1:0]   dato_q, res_d;
  logic [2:0]     op_q;
  logic [W:0]     add_full, sub_full;
  logic           sh_big;
  logic           accept, s2_load, s1_move;
  logic           unused_instr;

  assign unused_instr = ^instr;

  // The output register frees up whenever it is empty or being drained this cycle.
  assign s2_load    = !out_valid_q || out_ready;
  assign s1_move    = s1_valid_q && s2_load;
  assign in_ready   = !s1_valid_q || s1_move;
  assign accept     = in_valid && in_ready;
  assign s1_valid_d = accept ? 1'b1 : (s1_move ? 1'b0 : s1_valid_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_sh_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_op_q <= instr[7:5];
        s1_sh_q <= instr[SHW-1:0];
        s1_a_q  <= A;
        s1_b_q  <= B;
      end
    end
  end

  always_comb begin
    add_full = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    sub_full = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    sh_big   = (int'(s1_sh_q) >= W);
    res_d    = '0;
    case (s1_op_q)
      3'd0: res_d = add_full[W-1:0];
      3'd1: res_d = ~s1_a_q;
      3'd2: res_d = sh_big ? '0 : (s1_a_q << s1_sh_q);
      3'd3: res_d = sh_big ? '0 : (s1_a_q >> s1_sh_q);
      3'd4: res_d = {{(W-1){1'b0}}, (s1_a_q == s1_b_q)};
      3'd5: res_d = {{(W-1){1'b0}}, (s1_a_q > s1_b_q)};
      3'd6: res_d = sub_full[W-1:0];
      3'd7: res_d = s1_a_q & s1_b_q;
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dato_q      <= '0;
      op_q        <= '0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        dato_q <= res_d;
        op_q   <= s1_op_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign dato_out  = dato_q;
  assign op_out    = op_q;

`ifdef ALU_FLAGS_EN
  logic [3:0] flags_q, flags_d;
  logic       c_d, v_d;

  // C is carry for ADD and no-borrow for SUB; V is signed overflow of the same two ops.
  always_comb begin
    c_d = 1'b0;
    v_d = 1'b0;
    if (s1_op_q == 3'd0) begin
      c_d = add_full[W];
      v_d = (s1_a_q[W-1] == s1_b_q[W-1]) && (res_d[W-1] != s1_a_q[W-1]);
    end else if (s1_op_q == 3'd6) begin
      c_d = ~sub_full[W];
      v_d = (s1_a_q[W-1] != s1_b_q[W-1]) && (res_d[W-1] != s1_a_q[W-1]);
    end
    flags_d = {c_d, (res_d == '0), res_d[W-1], v_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 4'b0;
    end else if (s2_load && s1_valid_q) begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: vector table, hand sequences for pipeline corners,
// and randomized traffic against an arithmetic reference model.
module tb_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] instr;
  logic [3:0] A, B, dato_out;
  logic [2:0] op_out;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [7:0]  instr16;
  logic [15:0] a16, b16, dato16;
  logic [2:0]  op16;
`ifdef ALU_FLAGS_EN
  logic [3:0] flags, flags16;
`endif

  alu_pipe #(.W(4), .SHW(3)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .dato_out(dato_out), .op_out(op_out)
`ifdef ALU_FLAGS_EN
    , .flags(flags)
`endif
  );

  alu_pipe #(.W(16), .SHW(3)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .instr(instr16),
    .A(a16), .B(b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .dato_out(dato16), .op_out(op16)
`ifdef ALU_FLAGS_EN
    , .flags(flags16)
`endif
  );

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sh;
    logic [3:0] exp;
  } vec_t;

  int pass_cnt = 0, total_cnt = 0, out_cnt = 0, stalls = 0;
  bit rand_bp = 1'b0;
  logic [6:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Reference ALU from the opcode definitions, evaluated in wide integers then truncated.
  function automatic longint model(input int w, input int op, input longint a, input longint b,
                                   input int sh);
    longint mask, r;
    mask = (longint'(1) << w) - 1;
    case (op)
      0: r = a + b;
      1: r = ~a;
      2: r = (sh >= w) ? 0 : (a << sh);
      3: r = (sh >= w) ? 0 : (a >> sh);
      4: r = (a == b) ? 1 : 0;
      5: r = (a > b) ? 1 : 0;
      6: r = a - b;
      default: r = a & b;
    endcase
    return r & mask;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] sh);
    logic [1:0] junk;
    junk = 2'($urandom);
    instr = {op, junk, sh};
    A = a;
    B = b;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept(input logic [6:0] exp);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        ok = 1'b1;
      end else begin
        stalls++;
      end
      tick();
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] sh, input logic [3:0] exp);
    drive(op, a, b, sh);
    wait_accept({op, exp});
  endtask

  task automatic hand_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] sh, input logic [3:0] exp, input logic [3:0] fl);
    drive(op, a, b, sh);
    @(negedge clk);
    chk("lat_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back({op, exp});
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_early_valid", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_dato", 32'(dato_out), 32'(exp));
    chk("lat_op", 32'(op_out), 32'(op));
`ifdef ALU_FLAGS_EN
    chk("lat_flags", 32'(flags), 32'(fl));
`else
    if (fl === 4'bx) $display("unused flag expectation");
`endif
    tick();
  endtask

  task automatic h16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] exp);
    instr16 = {op, 5'b0};
    a16 = a;
    b16 = b;
    in_valid16 = 1'b1;
    @(negedge clk);
    chk("w16_in_ready", 32'(in_ready16), 32'd1);
    tick();
    in_valid16 = 1'b0;
    tick();
    @(negedge clk);
    chk("w16_valid", 32'(out_valid16), 32'd1);
    chk("w16_dato", 32'(dato16), 32'(exp));
    chk("w16_model", 32'(dato16), 32'(model(16, int'(op), longint'(a), longint'(b), 0)));
    tick();
  endtask

  // Scoreboard: every output handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (out_valid && out_ready) begin
      chk("out_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [6:0] e;
        e = exp_q.pop_front();
        chk("op_out", 32'(op_out), 32'(e[6:4]));
        chk("dato_out", 32'(dato_out), 32'(e[3:0]));
        out_cnt++;
      end
    end
  end

  initial begin
    vec_t tbl[14];
    int base;
    logic [3:0] held;

    tbl[0]  = '{3'd0, 4'b1010, 4'b0011, 3'd1, 4'b1101};
    tbl[1]  = '{3'd1, 4'b1010, 4'b0011, 3'd1, 4'b0101};
    tbl[2]  = '{3'd2, 4'b1010, 4'b0011, 3'd1, 4'b0100};
    tbl[3]  = '{3'd3, 4'b1010, 4'b0011, 3'd1, 4'b0101};
    tbl[4]  = '{3'd4, 4'b1010, 4'b0011, 3'd1, 4'b0000};
    tbl[5]  = '{3'd5, 4'b1010, 4'b0011, 3'd1, 4'b0001};
    tbl[6]  = '{3'd6, 4'b1010, 4'b0011, 3'd1, 4'b0111};
    tbl[7]  = '{3'd7, 4'b1010, 4'b0011, 3'd1, 4'b0010};
    tbl[8]  = '{3'd2, 4'b1111, 4'b0000, 3'd5, 4'b0000};
    tbl[9]  = '{3'd3, 4'b1111, 4'b0000, 3'd5, 4'b0000};
    tbl[10] = '{3'd6, 4'b0000, 4'b0001, 3'd0, 4'b1111};
    tbl[11] = '{3'd0, 4'b1001, 4'b1001, 3'd0, 4'b0010};
    tbl[12] = '{3'd4, 4'b0101, 4'b0101, 3'd0, 4'b0001};
    tbl[13] = '{3'd5, 4'b0011, 4'b0011, 3'd0, 4'b0000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; instr = '0; A = '0; B = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; instr16 = '0; a16 = '0; b16 = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dato", 32'(dato_out), 32'd0);
    chk("rst_op", 32'(op_out), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    hand_op(3'd0, 4'd9, 4'd9, 3'd0, 4'd2, 4'b1001);
    hand_op(3'd6, 4'd0, 4'd1, 3'd0, 4'b1111, 4'b0010);

    stalls = 0;
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, tbl[i].exp);
      if (i == 7) chk("stream_no_stall", 32'(stalls), 32'd0);
    end
    repeat (4) tick();
    chk("table_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: two ops fill the pipe, the third must wait with the output frozen.
    base = out_cnt;
    out_ready = 1'b0;
    send(3'd0, 4'd3, 4'd4, 3'd0, 4'd7);
    send(3'd1, 4'd5, 4'd0, 3'd0, 4'b1010);
    drive(3'd7, 4'hF, 4'h6, 3'd0);
    held = 4'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_held_dato", 32'(dato_out), 32'(held));
      chk("bp_held_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    wait_accept({3'd7, 4'h6});
    repeat (4) tick();
    chk("bp_emitted", 32'(out_cnt - base), 32'd3);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two ops in flight: nothing from before the reset may emerge.
    out_ready = 1'b0;
    send(3'd0, 4'd1, 4'd1, 3'd0, 4'd2);
    send(3'd0, 4'd2, 4'd2, 3'd0, 4'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_dato", 32'(dato_out), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    tick();

    h16(3'd5, 16'h8000, 16'h7FFF, 16'h0001);
    h16(3'd5, 16'h7FFF, 16'h8000, 16'h0000);
    h16(3'd4, 16'hBEEF, 16'hBEEF, 16'h0001);
    h16(3'd0, 16'hFFFF, 16'h0002, 16'h0001);

    // Random traffic with random backpressure against the reference model.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [2:0] op, sh;
      logic [3:0] a, b, e;
      op = 3'($urandom);
      sh = 3'($urandom);
      a = 4'($urandom);
      b = 4'($urandom);
      e = 4'(model(4, int'(op), longint'(a), longint'(b), int'(sh)));
      send(op, a, b, sh, e);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
